alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multi-cycle controller for the ALU datapath: ALU, shifter, divider, HiLo register and output MUX.
- Accepts one funct code per start/ready handshake and routes it to the unit that executes it.
- Runs the 32-cycle DIVU sequence, commits the quotient and remainder to HiLo, then steers the output MUX and reports done.
- Executes exactly one operation at a time, so an MFHI or MFLO issued after DIVU always reads the committed result.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles.
- CNT_W, 6, width of the iteration counter; must hold DIV_CYCLES-1.
- IDLE_SEL, 6'b111111, select value driven when a unit is unused. It is not a legal funct, so each unit falls to its default; note that 6'b000000 is SLL.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  operation request; sampled only while ready=1.
- Signal  input  6  funct code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, DIVU 011011, MFHI 010000, MFLO 010010.
- ready  output  1  high when state is IDLE; decoded from state.
- done  output  1  one-cycle pulse; the MUX output is valid in this cycle.
- illegal  output  1  high together with done when the accepted funct is unknown.
- SignaltoALU  output  6  ALU function select.
- SignaltoSHT  output  6  shifter function select.
- SignaltoDIV  output  6  divider function select.
- SignaltoMUX  output  6  output MUX select.
- div_start  output  1  one-cycle pulse that loads the divider operands.
- hilo_we  output  1  one-cycle HiLo write enable.

Behaviour:
- All state and outputs are registered except ready.
- Reset (reset=0 at a rising edge):
  - state=IDLE, counter=0, op register=IDLE_SEL.
  - done=0, illegal=0, div_start=0, hilo_we=0.
  - All four select outputs = IDLE_SEL.
  - ready reads 1 during and after reset.
- States: IDLE, EXEC, DIV, HILO, DONE.
- IDLE:
  - If start=1 at an edge, latch Signal into op.
  - AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO go to EXEC. DIVU goes to DIV. Any other code goes to EXEC with illegal flagged.
  - If start=0, remain in IDLE.
- EXEC (1 cycle):
  - ALU ops: SignaltoALU=op. SLL: SignaltoSHT=op.
  - SignaltoMUX=op for all legal codes.
  - done=1. illegal=1 only for an unknown code; all selects stay at IDLE_SEL in that case.
  - Next state: IDLE.
  - Latency: done is high in the cycle immediately after the acceptance edge.
- DIV:
  - SignaltoDIV=DIVU throughout.
  - div_start=1 only in the first DIV cycle (counter=0).
  - counter increments each cycle.
  - When counter=DIV_CYCLES-1, go to HILO and clear counter to 0.
- HILO (1 cycle): hilo_we=1, SignaltoDIV=DIVU. Next state: DONE.
- DONE (1 cycle):
  - done=1, SignaltoMUX=DIVU (MUX output reads 0 for DIVU).
  - Next state: IDLE.
  - DIVU latency with the defaults: acceptance at edge 0, DIV occupies cycles 1..32, hilo_we in cycle 33, done in cycle 34.
- Unit selects not used by the current state are IDLE_SEL.
- done, div_start and hilo_we are never high for more than one cycle per operation.
- start while ready=0: ignored. No queueing, and the op register is unchanged.
- Signal changes mid-operation: ignored; only the latched op is used.
- Back-to-back operations: start held high during done is accepted on the edge that returns to IDLE's first cycle. Sustained throughput is one operation per 2 cycles for single-cycle ops.
- Reset mid-operation: reset wins over all transitions. It aborts DIV or HILO with no hilo_we and no done, and the counter returns to 0.
- Counter wrap: the counter never exceeds DIV_CYCLES-1, and it is cleared on exit and on reset.

Test Plan:
- Reset held 3 cycles, then released -> ready=1; done, hilo_we and div_start=0; all selects=6'b111111.
- start with Signal=100000 (ADD) -> next cycle done=1, SignaltoALU=100000, SignaltoMUX=100000, illegal=0; the following cycle ready=1 and selects return to 6'b111111.
- start with Signal=011011 (DIVU) -> div_start pulses in cycle 1, ready=0 for cycles 1-34, hilo_we only in cycle 33, done only in cycle 34. Follow with MFHI -> done 1 cycle later with SignaltoMUX=010000.
- Mid-DIVU, pulse start with Signal=100100 -> ignored, DIVU timing unchanged, no extra done.
- Reset asserted in DIV cycle 10 -> no hilo_we and no done ever; state IDLE; a new start with SLL (000000) -> SignaltoSHT=000000, done after 1 cycle.
- start with Signal=111000 -> next cycle done=1 and illegal=1, all selects=6'b111111; then IDLE.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Handshake and unit-select bundle between the ALU sequencer and its
// requester/datapath. The master drives requests; the slave (the sequencer)
// drives status and the per-unit function selects.
interface alu_sequencer_if;
  logic       start;
  logic [5:0] Signal;
  logic       ready;
  logic       done;
  logic       illegal;
  logic [5:0] SignaltoALU;
  logic [5:0] SignaltoSHT;
  logic [5:0] SignaltoDIV;
  logic [5:0] SignaltoMUX;
  logic       div_start;
  logic       hilo_we;

  modport master (
    output start, Signal,
    input  ready, done, illegal,
    input  SignaltoALU, SignaltoSHT, SignaltoDIV, SignaltoMUX,
    input  div_start, hilo_we
  );

  modport slave (
    input  start, Signal,
    output ready, done, illegal,
    output SignaltoALU, SignaltoSHT, SignaltoDIV, SignaltoMUX,
    output div_start, hilo_we
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the ALU datapath. Accepts one funct code per
// start/ready handshake, steers it to the ALU, shifter or divider, runs the
// DIVU iteration sequence, commits HiLo and reports done.
// All outputs except ready are registered: the value each output takes in a
// state is decided on the edge that enters that state.
module alu_sequencer #(
  parameter int         DIV_CYCLES = 32,
  parameter int         CNT_W      = 6,
  parameter logic [5:0] IDLE_SEL   = 6'b111111
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXEC, DIV, HILO, DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             div_start_q, div_start_d;
  logic             hilo_we_q, hilo_we_d;
  logic [5:0]       alu_q, alu_d;
  logic [5:0]       sht_q, sht_d;
  logic [5:0]       div_q, div_d;
  logic [5:0]       mux_q, mux_d;

  // ready is the only combinational output; it also reads 1 while reset is held
  assign bus.ready       = (state_q == IDLE) || !reset;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.div_start   = div_start_q;
  assign bus.hilo_we     = hilo_we_q;
  assign bus.SignaltoALU = alu_q;
  assign bus.SignaltoSHT = sht_q;
  assign bus.SignaltoDIV = div_q;
  assign bus.SignaltoMUX = mux_q;

  // State, counter, op and registered outputs; reset overrides every transition
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= IDLE_SEL;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      div_start_q <= 1'b0;
      hilo_we_q   <= 1'b0;
      alu_q       <= IDLE_SEL;
      sht_q       <= IDLE_SEL;
      div_q       <= IDLE_SEL;
      mux_q       <= IDLE_SEL;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      div_start_q <= div_start_d;
      hilo_we_q   <= hilo_we_d;
      alu_q       <= alu_d;
      sht_q       <= sht_d;
      div_q       <= div_d;
      mux_q       <= mux_d;
    end
  end

  // Next state plus the output values the next state must present
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    div_start_d = 1'b0;
    hilo_we_d   = 1'b0;
    alu_d       = IDLE_SEL;
    sht_d       = IDLE_SEL;
    div_d       = IDLE_SEL;
    mux_d       = IDLE_SEL;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Decode from the live code: op_q only becomes valid on this edge
          op_d = bus.Signal;
          case (bus.Signal)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
              state_d = EXEC;
              done_d  = 1'b1;
              alu_d   = bus.Signal;
              mux_d   = bus.Signal;
            end
            F_SLL: begin
              state_d = EXEC;
              done_d  = 1'b1;
              sht_d   = bus.Signal;
              mux_d   = bus.Signal;
            end
            F_MFHI, F_MFLO: begin
              state_d = EXEC;
              done_d  = 1'b1;
              mux_d   = bus.Signal;
            end
            F_DIVU: begin
              state_d     = DIV;
              cnt_d       = '0;
              div_start_d = 1'b1;
              div_d       = bus.Signal;
            end
            default: begin
              // Unknown code: report it, but leave every unit deselected
              state_d   = EXEC;
              done_d    = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        state_d = IDLE;
      end
      DIV: begin
        div_d = op_q;
        if (cnt_q == CNT_LAST) begin
          state_d   = HILO;
          cnt_d     = '0;
          hilo_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HILO: begin
        state_d = DONE;
        done_d  = 1'b1;
        mux_d   = op_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
